// File: rtl/mem_pkg.sv
// Shared definitions for the memory-access stage: opcode encodings, FSM
// state encoding and small opcode-decode helpers.
package mem_pkg;

  localparam int OPT_W = 6;

  typedef logic [OPT_W-1:0] opcode_t;

  localparam opcode_t OP_NOP = 6'd0;
  localparam opcode_t OP_LB  = 6'd1;
  localparam opcode_t OP_LH  = 6'd2;
  localparam opcode_t OP_LW  = 6'd3;
  localparam opcode_t OP_LBU = 6'd4;
  localparam opcode_t OP_LHU = 6'd5;
  localparam opcode_t OP_SB  = 6'd6;
  localparam opcode_t OP_SH  = 6'd7;
  localparam opcode_t OP_SW  = 6'd8;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  function automatic logic is_load(input opcode_t op);
    return op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
  endfunction

  function automatic logic is_store(input opcode_t op);
    return op inside {OP_SB, OP_SH, OP_SW};
  endfunction

  function automatic logic is_mem(input opcode_t op);
    return is_load(op) || is_store(op);
  endfunction

  // Number of bytes moved by a memory opcode (0 for non-memory ops).
  function automatic logic [2:0] byte_count(input opcode_t op);
    case (op)
      OP_LB, OP_LBU, OP_SB: return 3'd1;
      OP_LH, OP_LHU, OP_SH: return 3'd2;
      OP_LW, OP_SW:         return 3'd4;
      default:              return 3'd0;
    endcase
  endfunction

  // Index of the final byte; a 4-byte count truncates to 0 and wraps to 3.
  function automatic logic [1:0] last_idx(input opcode_t op);
    logic [2:0] n;
    n = byte_count(op);
    return n[1:0] - 2'd1;
  endfunction

endpackage

// File: rtl/mem_load_ext.sv
// Width select and sign/zero extension of the byte-assembled load word.
module mem_load_ext #(
  parameter int XLEN = 32
) (
  input  logic [mem_pkg::OPT_W-1:0] op,
  input  logic [XLEN-1:0]           word,
  output logic [XLEN-1:0]           val
);
  import mem_pkg::*;

  // Pick the loaded width and extend it to XLEN.
  always_comb begin
    val = word;
    case (op)
      OP_LB:   val = {{(XLEN-8){word[7]}}, word[7:0]};
      OP_LBU:  val = {{(XLEN-8){1'b0}}, word[7:0]};
      OP_LH:   val = {{(XLEN-16){word[15]}}, word[15:0]};
      OP_LHU:  val = {{(XLEN-16){1'b0}}, word[15:0]};
      default: val = word;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage. ALU results pass straight through; loads and
// stores run byte-serially against the memory controller while stall_req
// holds the front of the pipeline.
//
// Memory handshake: mc_req is the valid, mc_ack the ready. A byte transfers on
// every rising edge where mc_req, mc_ack and rdy are all high; mc_addr and
// mc_wdata stay stable until that edge and mc_rdata is sampled on it.
module mem_stage #(
  parameter int OPT_W = mem_pkg::OPT_W,
  parameter int XLEN  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic [OPT_W-1:0] ex_inst,
  input  logic [4:0]       ex_rd,
  input  logic [XLEN-1:0]  ex_vd,
  input  logic             ex_w_enable,
  input  logic [XLEN-1:0]  ex_addr,
  input  logic             stall_hold,
  output logic             mc_req,
  output logic             mc_wr,
  output logic [XLEN-1:0]  mc_addr,
  output logic [7:0]       mc_wdata,
  input  logic             mc_ack,
  input  logic [7:0]       mc_rdata,
  output logic             stall_req,
  output logic [4:0]       wb_rd,
  output logic [XLEN-1:0]  wb_vd,
  output logic             wb_w_enable,
  output logic [1:0]       dbg_state
);
  import mem_pkg::*;

  state_t          state;
  logic [1:0]      cnt;
  opcode_t         op_c;
  opcode_t         op_q;
  logic [XLEN-1:0] base_q;
  logic [XLEN-1:0] sd_q;
  logic [XLEN-1:0] asm_q;
  logic [4:0]      rd_q;
  logic [XLEN-1:0] ld_val;

  assign op_c      = opcode_t'(ex_inst);
  assign dbg_state = state;

  mem_load_ext #(.XLEN(XLEN)) u_ext (
    .op   (op_q),
    .word (asm_q),
    .val  (ld_val)
  );

  // Transaction FSM: latch the op in IDLE, gather/issue bytes in ACCESS,
  // present the result in DONE until the downstream stage is free.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= S_IDLE;
      cnt    <= 2'd0;
      op_q   <= OP_NOP;
      base_q <= '0;
      sd_q   <= '0;
      asm_q  <= '0;
      rd_q   <= 5'd0;
    end else if (rdy) begin
      case (state)
        S_IDLE: begin
          if (is_mem(op_c)) begin
            op_q   <= op_c;
            base_q <= ex_addr;
            sd_q   <= ex_vd;
            rd_q   <= ex_rd;
            asm_q  <= '0;
            cnt    <= 2'd0;
            state  <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (mc_ack) begin
            asm_q[{cnt, 3'b000} +: 8] <= mc_rdata;
            cnt <= cnt + 2'd1;
            if (cnt == last_idx(op_q)) state <= S_DONE;
          end
        end
        S_DONE: begin
          if (!stall_hold) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Output decode from the current state and latched transaction.
  always_comb begin
    mc_req      = 1'b0;
    mc_wr       = 1'b0;
    mc_addr     = '0;
    mc_wdata    = 8'd0;
    stall_req   = 1'b0;
    wb_rd       = ex_rd;
    wb_vd       = ex_vd;
    wb_w_enable = ex_w_enable;
    case (state)
      S_IDLE: begin
        if (is_mem(op_c)) begin
          stall_req   = 1'b1;
          wb_w_enable = 1'b0;
        end
      end
      S_ACCESS: begin
        mc_req      = 1'b1;
        mc_wr       = is_store(op_q);
        mc_addr     = base_q + XLEN'(cnt);
        if (is_store(op_q)) mc_wdata = sd_q[{cnt, 3'b000} +: 8];
        stall_req   = 1'b1;
        wb_rd       = 5'd0;
        wb_vd       = '0;
        wb_w_enable = 1'b0;
      end
      S_DONE: begin
        if (is_load(op_q)) begin
          wb_rd       = rd_q;
          wb_vd       = ld_val;
          wb_w_enable = 1'b1;
        end else begin
          wb_rd       = 5'd0;
          wb_vd       = '0;
          wb_w_enable = 1'b0;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with a byte-wide memory controller model.
module tb_mem_stage;

  localparam logic [5:0] NOP = 6'd0, LB = 6'd1, LH = 6'd2, LW = 6'd3,
                         LBU = 6'd4, LHU = 6'd5, SH = 6'd7, SW = 6'd8;
  localparam logic [1:0] ST_IDLE = 2'd0, ST_DONE = 2'd2;

  logic        clk, rst, rdy;
  logic [5:0]  ex_inst;
  logic [4:0]  ex_rd;
  logic [31:0] ex_vd, ex_addr;
  logic        ex_w_enable, stall_hold;
  logic        mc_req, mc_wr, mc_ack;
  logic [31:0] mc_addr;
  logic [7:0]  mc_wdata, mc_rdata;
  logic        stall_req;
  logic [4:0]  wb_rd;
  logic [31:0] wb_vd;
  logic        wb_w_enable;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  // Memory model state: byte array, ack delay, transfer logs, expectations.
  logic [7:0]  mem [16];
  int          ack_delay;
  int          wait_q;
  logic [31:0] addr_log[$];
  logic [7:0]  wdata_log[$];
  logic [31:0] exp_q[$];
  logic [7:0]  exp_wq[$];

  mem_stage dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .ex_inst(ex_inst), .ex_rd(ex_rd), .ex_vd(ex_vd),
    .ex_w_enable(ex_w_enable), .ex_addr(ex_addr), .stall_hold(stall_hold),
    .mc_req(mc_req), .mc_wr(mc_wr), .mc_addr(mc_addr), .mc_wdata(mc_wdata),
    .mc_ack(mc_ack), .mc_rdata(mc_rdata), .stall_req(stall_req),
    .wb_rd(wb_rd), .wb_vd(wb_vd), .wb_w_enable(wb_w_enable),
    .dbg_state(dbg_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Controller model: ack on the (ack_delay+1)-th cycle a byte is presented,
  // held until the stage consumes it (rdy high).
  assign mc_ack   = mc_req && (wait_q >= ack_delay);
  assign mc_rdata = mem[mc_addr[3:0]];

  always @(posedge clk) begin
    if (!rst) begin
      wait_q <= 0;
    end else if (mc_req && mc_ack && rdy) begin
      wait_q <= 0;
      addr_log.push_back(mc_addr);
      if (mc_wr) wdata_log.push_back(mc_wdata);
    end else if (mc_req) begin
      wait_q <= wait_q + 1;
    end else begin
      wait_q <= 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Compare serviced bytes against the expected queues, then empty everything.
  task automatic check_logs(input string tag);
    check({tag, "_nbytes"}, 32'(addr_log.size()), 32'(exp_q.size()));
    check({tag, "_nwr"}, 32'(wdata_log.size()), 32'(exp_wq.size()));
    while (exp_q.size() > 0 && addr_log.size() > 0)
      check({tag, "_addr"}, addr_log.pop_front(), exp_q.pop_front());
    while (exp_wq.size() > 0 && wdata_log.size() > 0)
      check({tag, "_wdata"}, 32'(wdata_log.pop_front()), 32'(exp_wq.pop_front()));
    addr_log.delete(); wdata_log.delete(); exp_q.delete(); exp_wq.delete();
  endtask

  // Run one memory op to DONE, checking write-back and stall length.
  task automatic mem_op(input string tag, input logic [5:0] op, input logic [4:0] rd,
                        input logic [31:0] vd, input logic [31:0] addr,
                        input logic [31:0] exp_vd, input logic exp_wen,
                        input logic [4:0] exp_rd, input int exp_stall,
                        input int rdy_off, input bit hold_done);
    int  stall;
    bit  done;
    stall = 0;
    done  = 0;
    @(negedge clk);
    ex_inst = op; ex_rd = rd; ex_vd = vd; ex_addr = addr; ex_w_enable = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (i == rdy_off) rdy = 1'b0;
      if (i == rdy_off + 2) rdy = 1'b1;
      #1;
      if (stall_req) stall++;
      if (dbg_state == ST_DONE) begin
        done = 1;
        break;
      end
      @(negedge clk);
    end
    rdy = 1'b1;
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_stall"}, 32'(stall), 32'(exp_stall));
    check({tag, "_wen"}, 32'(wb_w_enable), 32'(exp_wen));
    check({tag, "_rd"}, 32'(wb_rd), 32'(exp_rd));
    if (exp_wen) check({tag, "_vd"}, wb_vd, exp_vd);
    check({tag, "_done_req"}, {30'd0, mc_req, stall_req}, 32'd0);
    ex_inst = NOP; ex_w_enable = 1'b0;
    if (hold_done) begin
      stall_hold = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      check({tag, "_hold_state"}, 32'(dbg_state), 32'(ST_DONE));
      stall_hold = 1'b0;
    end
    @(negedge clk);
    #1;
    check({tag, "_back_idle"}, 32'(dbg_state), 32'(ST_IDLE));
    check_logs(tag);
  endtask

  initial begin
    rst = 1'b0; rdy = 1'b1; stall_hold = 1'b0;
    ex_inst = NOP; ex_rd = 5'd0; ex_vd = 32'd0; ex_addr = 32'd0; ex_w_enable = 1'b0;
    ack_delay = 0;
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;

    // Reset state
    #1;
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    check("rst_mc", {mc_req, mc_wr, mc_wdata, 22'd0}, 32'd0);
    check("rst_addr", mc_addr, 32'd0);
    check("rst_stall", 32'(stall_req), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // ALU pass-through, two patterns
    @(negedge clk);
    ex_inst = 6'h20; ex_rd = 5'd5; ex_vd = 32'h1234; ex_w_enable = 1'b1;
    #1;
    check("alu_rd", 32'(wb_rd), 32'd5);
    check("alu_vd", wb_vd, 32'h1234);
    check("alu_wen", 32'(wb_w_enable), 32'd1);
    check("alu_stall", 32'(stall_req), 32'd0);
    @(negedge clk);
    ex_inst = 6'h3F; ex_rd = 5'd31; ex_vd = 32'hCAFE_0001; ex_w_enable = 1'b0;
    #1;
    check("alu2_vd", wb_vd, 32'hCAFE_0001);
    check("alu2_rd_wen", {26'd0, wb_rd, wb_w_enable}, {26'd0, 5'd31, 1'b0});
    check("alu2_req", {30'd0, mc_req, stall_req}, 32'd0);
    check_logs("alu");

    // LW, single-cycle ack
    mem[0] = 8'h78; mem[1] = 8'h56; mem[2] = 8'h34; mem[3] = 8'h12;
    exp_q = '{32'h1000, 32'h1001, 32'h1002, 32'h1003};
    mem_op("lw", LW, 5'd7, 32'h0, 32'h1000, 32'h12345678, 1'b1, 5'd7, 5, -1, 0);

    // LB / LBU on 0x80, LH on 0x00,0x80
    mem[5] = 8'h80;
    exp_q = '{32'h1005};
    mem_op("lb", LB, 5'd3, 32'h0, 32'h1005, 32'hFFFFFF80, 1'b1, 5'd3, 2, -1, 0);
    exp_q = '{32'h1005};
    mem_op("lbu", LBU, 5'd4, 32'h0, 32'h1005, 32'h00000080, 1'b1, 5'd4, 2, -1, 0);
    mem[8] = 8'h00; mem[9] = 8'h80;
    exp_q = '{32'h1008, 32'h1009};
    mem_op("lh", LH, 5'd6, 32'h0, 32'h1008, 32'hFFFF8000, 1'b1, 5'd6, 3, -1, 0);

    // SH wrapping past the top of the address space
    exp_q = '{32'hFFFFFFFF, 32'h00000000};
    exp_wq = '{8'hCD, 8'hAB};
    mem_op("sh", SH, 5'd2, 32'hABCD, 32'hFFFFFFFF, 32'h0, 1'b0, 5'd0, 3, -1, 0);

    // SW: ack in the 4th cycle of each byte, rdy low for the first two
    // cycles of byte 1 -> stall 1 + 4*4 = 17; then stall_hold in DONE
    ack_delay = 3;
    exp_q = '{32'h3000, 32'h3001, 32'h3002, 32'h3003};
    exp_wq = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    mem_op("sw", SW, 5'd1, 32'hDEADBEEF, 32'h3000, 32'h0, 1'b0, 5'd0, 17, 5, 1);
    ack_delay = 0;

    // Reset pulsed while byte 2 of an LW is presented
    @(negedge clk);
    ex_inst = LW; ex_rd = 5'd9; ex_addr = 32'h1000; ex_w_enable = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("rstmid_byte2", mc_addr, 32'h1002);
    ex_inst = NOP; ex_w_enable = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("rstmid_req", 32'(mc_req), 32'd0);
    check("rstmid_state", 32'(dbg_state), 32'(ST_IDLE));
    check("rstmid_wb", {30'd0, wb_w_enable, stall_req}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("rstmid_nowb", {29'd0, wb_w_enable, mc_req, stall_req}, 32'd0);
    exp_q = '{32'h1000, 32'h1001};
    check_logs("rstmid");

    // Clean LHU after the abort
    mem[10] = 8'hFE; mem[11] = 8'hFF;
    exp_q = '{32'h100A, 32'h100B};
    mem_op("lhu", LHU, 5'd12, 32'h0, 32'h100A, 32'h0000FFFE, 1'b1, 5'd12, 3, -1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access pipeline stage sitting between the EX/MEM pipeline register and the MEM/WB register. It takes the opcode, destination, value and address latched by EX/MEM. ALU results pass through combinationally. Loads and stores run as a byte-serial transaction against the memory controller, and the stage holds the pipeline with a stall request until the access completes.

## Interface
Parameters:
- OPT_W, 6: opcode width; encodings come from mem_pkg.
- XLEN, 32: data and address width.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- rdy  in  1  global enable; when low, all state and registered outputs hold.
- ex_inst  in  OPT_W  opcode from EX/MEM.
- ex_rd  in  5  destination register address.
- ex_vd  in  XLEN  ALU result, or store data for stores.
- ex_w_enable  in  1  register-write enable.
- ex_addr  in  XLEN  effective memory address.
- stall_hold  in  1  a downstream stage is stalled (stall_ctrler[3]).
- mc_req  out  1  byte request to the memory controller.
- mc_wr  out  1  1 = write, 0 = read.
- mc_addr  out  XLEN  byte address.
- mc_wdata  out  8  write byte.
- mc_ack  in  1  current byte is serviced; mc_rdata is valid in the same cycle.
- mc_rdata  in  8  read byte.
- stall_req  out  1  hold IF through EX/MEM.
- wb_rd  out  5  destination register to MEM/WB.
- wb_vd  out  XLEN  write-back value.
- wb_w_enable  out  1  write-back enable.

## Operation
- Opcodes (mem_pkg): NOP=0, LB=1, LH=2, LW=3, LBU=4, LHU=5, SB=6, SH=7, SW=8. Any other value is a non-memory operation.
- Byte count n: 1 for B/BU, 2 for H/HU, 4 for W.
- State machine states: IDLE, ACCESS, DONE.
- IDLE:
  - Non-memory op: wb_* = ex_rd/ex_vd/ex_w_enable combinationally; stall_req=0.
  - Memory op: stall_req=1 and wb_w_enable=0. Latch the opcode, address, store data and rd. Clear cnt. Go to ACCESS.
- ACCESS:
  - mc_req=1; mc_addr = base + cnt, mod 2^XLEN (wraps).
  - mc_wr=1 for stores. mc_wdata = store byte cnt, little-endian (byte 0 = bits 7:0).
  - On each edge with mc_ack=1: capture mc_rdata into assembly byte cnt, then cnt++.
  - When the captured byte is byte n-1, go to DONE.
  - mc_ack while mc_req=0 is ignored.
- DONE:
  - mc_req=0 and stall_req=0.
  - Loads: wb_vd = assembled value; LB/LH sign-extend, LBU/LHU zero-extend. wb_rd = latched rd; wb_w_enable=1.
  - Stores: wb_w_enable=0 and wb_rd=0.
  - Go to IDLE on the next edge where stall_hold=0; stay in DONE while stall_hold=1.
- rdy=0 freezes the state, cnt, latches and assembly register; combinational outputs still follow the frozen state.
- Reset mid-transaction returns the stage to IDLE immediately and drops mc_req. The memory controller must abandon any partial access.

## Timing
- Reset values:
  - state=IDLE, cnt=0, latches=0.
  - mc_req=0, mc_wr=0, mc_addr=0, mc_wdata=0.
  - stall_req=0.
  - wb_* follow the IDLE rule for the current ex_* inputs.
- Non-memory op: zero latency, combinational.
- Memory op with acks k_i cycles after each byte is presented (k_i ≥ 1): stall_req is high for 1 + Σk_i cycles, then DONE lasts one cycle.
  - With single-cycle ack: n+2 cycles total.
- mc_req stays high continuously across the bytes of one access. Address and data change on the edge after each ack.
- stall_req is deasserted in DONE, so EX/MEM advances on the DONE→IDLE edge. A back-to-back memory op starts cleanly from IDLE.
- The MEM/WB register captures wb_* at the DONE→IDLE edge.

## Structure
- mem_pkg: OPT_W, opcode constants, state encoding, and a byte-count function.
- Natural sub-module: mem_load_ext, a combinational width select and sign/zero extension of the assembled word.
- The rest of the logic is one FSM module.

## Test plan
- ALU pass-through: ex_inst=0x20, rd=5, vd=0x1234, w_en=1 → wb_* match inputs in the same cycle; stall_req=0; mc_req never rises.
- LW at 0x1000, memory bytes 0x78,0x56,0x34,0x12, single-cycle ack → mc_addr sequence 0x1000..0x1003; wb_vd=0x12345678 in DONE; stall_req high for exactly 5 cycles.
- LB and LBU at a byte holding 0x80 → LB gives 0xFFFFFF80, LBU gives 0x00000080. LH on bytes 0x00,0x80 gives 0xFFFF8000.
- SH of vd=0xABCD at 0xFFFFFFFF → writes 0xCD at 0xFFFFFFFF, then 0xAB at 0x00000000 (wrap); wb_w_enable=0.
- SW with ack delayed 3 cycles per byte, plus rdy=0 for 2 cycles mid-access → stall_req high for 17 cycles total, no byte skipped or repeated; stall_hold=1 in DONE keeps DONE.
- rst pulsed low during byte 2 of LW → mc_req=0 and state=IDLE immediately; no write-back occurs.
